// File: rtl/ni_resp_pkg.sv
// Shared AXI/packet response codes plus the response mapping and byte-swap
// helpers used by the NI response path.
package ni_resp_pkg;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    PR_DVA  = 2'b00,
    PR_FAIL = 2'b01,
    PR_ERR  = 2'b10
  } packet_resp_e;

  localparam int MAX_DATA_WD = 512;

  // A plain OKAY on a locked beat means the exclusive/locked access was lost.
  function automatic packet_resp_e map_resp(input axi_resp_e resp, input logic locked);
    case (resp)
      AXI_OKAY:   return locked ? PR_FAIL : PR_DVA;
      AXI_EXOKAY: return PR_DVA;
      default:    return PR_ERR;
    endcase
  endfunction

  // Reverse the whole max-width vector, then shift the reversed bytes down so
  // only the low nbytes bytes of the input take part.
  function automatic logic [MAX_DATA_WD-1:0] byte_swap(input logic [MAX_DATA_WD-1:0] data,
                                                        input int nbytes);
    logic [MAX_DATA_WD-1:0] rev;
    for (int i = 0; i < MAX_DATA_WD/8; i++) begin
      rev[i*8 +: 8] = data[MAX_DATA_WD-8-i*8 +: 8];
    end
    return rev >> (MAX_DATA_WD - 8*nbytes);
  endfunction

endpackage

// File: rtl/axi_ni_resp_encode.sv
// Combinational capture-side encoder: endianness normalisation of the read
// data and AXI-to-packet response mapping, producing one buffer payload word.
module axi_ni_resp_encode
  import ni_resp_pkg::*;
#(
  parameter int AXIRDATAWD = 32,
  parameter int ENDIANNESS = 0
) (
  input  logic [AXIRDATAWD-1:0] in_data,
  input  logic [1:0]            in_resp,
  input  logic                  in_locked,
  output logic [AXIRDATAWD+1:0] payload
);

  logic [AXIRDATAWD-1:0] data_norm;
  packet_resp_e          resp_code;

  always_comb begin
    data_norm = in_data;
    if (ENDIANNESS == 1) begin
      data_norm = AXIRDATAWD'(byte_swap(MAX_DATA_WD'(in_data), AXIRDATAWD/8));
    end
    resp_code = map_resp(axi_resp_e'(in_resp), in_locked);
    payload   = {resp_code, data_norm};
  end

endmodule

// File: rtl/axi_ni_resend_payload_buffer.sv
// Response-payload buffer holding entries until the network acks them so a
// nacked train can be replayed. Macro NI_RESEND_REPLAY_EN enables ack/nack
// replay; without it the block is a plain FIFO freeing entries on send.
module axi_ni_resend_payload_buffer
  import ni_resp_pkg::*;
#(
  parameter int AXIRDATAWD = 32,
  parameter int DEPTH      = 4,
  parameter int ENDIANNESS = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AXIRDATAWD-1:0]   in_data,
  input  logic [1:0]              in_resp,
  input  logic                    in_locked,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AXIRDATAWD+1:0]   out_payload,
  input  logic                    ack,
  input  logic                    nack,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PAYLOADWD = AXIRDATAWD + 2;
  localparam int AW        = $clog2(DEPTH);
  localparam int PW        = AW + 1;

  logic [PAYLOADWD-1:0] mem [DEPTH];
  logic [PAYLOADWD-1:0] enc_payload;
  logic [PW-1:0]        wr;
  logic [PW-1:0]        rd;
  logic [PW-1:0]        cm;
  logic                 push;
  logic                 pop;

  axi_ni_resp_encode #(
    .AXIRDATAWD (AXIRDATAWD),
    .ENDIANNESS (ENDIANNESS)
  ) u_encode (
    .in_data   (in_data),
    .in_resp   (in_resp),
    .in_locked (in_locked),
    .payload   (enc_payload)
  );

  // Occupancy spans from the oldest unacked entry to the allocate pointer.
  assign count       = wr - cm;
  assign full        = (count == PW'(DEPTH));
  assign empty       = (count == '0);
  assign in_ready    = !full;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_payload = mem[rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr <= '0;
    end else if (push) begin
      mem[wr[AW-1:0]] <= enc_payload;
      wr              <= wr + PW'(1);
    end
  end

`ifdef NI_RESEND_REPLAY_EN
  logic          ack_eff;
  logic [PW-1:0] cm_next;

  // An ack with nothing in flight is dropped; nack rewinds past any same-cycle ack.
  assign ack_eff   = ack && (cm != rd);
  assign cm_next   = cm + PW'(ack_eff);
  assign out_valid = (rd != wr) && !nack;

  always_ff @(posedge clk) begin
    if (rst) begin
      cm <= '0;
      rd <= '0;
    end else begin
      cm <= cm_next;
      if (nack) begin
        rd <= cm_next;
      end else if (pop) begin
        rd <= rd + PW'(1);
      end
    end
  end
`else
  logic unused_ctrl;

  assign unused_ctrl = ack ^ nack;
  assign out_valid   = (rd != wr);
  assign cm          = rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
    end else if (pop) begin
      rd <= rd + PW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axi_ni_resend_payload_buffer.sv
// Bench for axi_ni_resend_payload_buffer: directed and random traffic checked
// against a queue-based occupancy/replay model; a big-endian twin shares inputs.
module tb_axi_ni_resend_payload_buffer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
`ifdef NI_RESEND_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic [1:0]    in_resp;
  logic          in_locked;
  logic          out_ready;
  logic          ack;
  logic          nack;
  logic          in_ready, out_valid, full, empty;
  logic [W+1:0]  out_payload;
  logic [2:0]    count;
  logic          be_in_ready, be_out_valid, be_full, be_empty;
  logic [W+1:0]  be_payload;
  logic [2:0]    be_count;

  logic [W+1:0]  q[$];
  int            sent;
  int            n_checks;
  int            n_pass;

  axi_ni_resend_payload_buffer #(.AXIRDATAWD(W), .DEPTH(DEPTH), .ENDIANNESS(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_resp(in_resp), .in_locked(in_locked), .out_valid(out_valid), .out_ready(out_ready),
    .out_payload(out_payload), .ack(ack), .nack(nack), .count(count), .full(full), .empty(empty)
  );

  axi_ni_resend_payload_buffer #(.AXIRDATAWD(W), .DEPTH(DEPTH), .ENDIANNESS(1)) dut_be (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(be_in_ready), .in_data(in_data),
    .in_resp(in_resp), .in_locked(in_locked), .out_valid(be_out_valid), .out_ready(out_ready),
    .out_payload(be_payload), .ack(ack), .nack(nack), .count(be_count), .full(be_full),
    .empty(be_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] bswap32(input logic [W-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [1:0] code_of(input logic [1:0] r, input logic lk);
    if (r == 2'b00) return lk ? 2'b01 : 2'b00;
    if (r == 2'b01) return 2'b00;
    return 2'b10;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_resp = '0; in_locked = 1'b0;
    out_ready = 1'b0; ack = 1'b0; nack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    sent = 0;
    #1;
    check_output("rst_count", 64'(count), 64'd0);
    check_output("rst_empty", 64'(empty), 64'd1);
    check_output("rst_full", 64'(full), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_payload", 64'(out_payload), 64'd0);
    check_output("rst_be_payload", 64'(be_payload), 64'd0);
    @(negedge clk);
  endtask

  // One clock: drive inputs, check against the model, then advance the model.
  task automatic apply_stimulus(input logic v, input logic [W-1:0] d, input logic [1:0] r,
                                input logic lk, input logic ordy, input logic a, input logic n);
    logic exp_valid;
    logic do_push;
    logic do_pop;
    logic ack_eff;
    in_valid = v; in_data = d; in_resp = r; in_locked = lk;
    out_ready = ordy; ack = a; nack = n;
    #1;
    exp_valid = REPLAY ? ((sent < q.size()) && !n) : (q.size() > 0);
    check_output("count", 64'(count), 64'(q.size()));
    check_output("full", 64'(full), 64'(q.size() == DEPTH));
    check_output("empty", 64'(empty), 64'(q.size() == 0));
    check_output("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check_output("out_valid", 64'(out_valid), 64'(exp_valid));
    check_output("be_out_valid", 64'(be_out_valid), 64'(exp_valid));
    if (exp_valid) begin
      check_output("payload", 64'(out_payload), 64'(q[sent]));
      check_output("be_payload", 64'(be_payload), 64'({q[sent][W+1:W], bswap32(q[sent][W-1:0])}));
    end
    do_push = v && (q.size() < DEPTH);
    do_pop  = exp_valid && ordy;
    @(posedge clk);
    if (REPLAY) begin
      ack_eff = a && (sent > 0);
      if (ack_eff) begin
        void'(q.pop_front());
        sent--;
      end
      if (do_pop) sent++;
      if (n) sent = 0;
    end else if (do_pop) begin
      void'(q.pop_front());
    end
    if (do_push) q.push_back({code_of(r, lk), d});
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    sent     = 0;
    @(negedge clk);
    do_reset();

    apply_stimulus(1, 32'h11223344, 2'b00, 0, 0, 0, 0);
    #1;
    check_output("first_valid", 64'(out_valid), 64'd1);
    check_output("first_le", 64'(out_payload), 64'h0_1122_3344);
    check_output("first_be", 64'(be_payload), 64'h0_4433_2211);
    apply_stimulus(0, 0, 2'b00, 0, 1, 0, 0);
    apply_stimulus(0, 0, 2'b00, 0, 0, 1, 0);

    apply_stimulus(1, 32'hA0A0_0001, 2'b00, 1, 0, 0, 0);
    apply_stimulus(1, 32'hA1A1_0002, 2'b01, 0, 0, 0, 0);
    apply_stimulus(1, 32'hA2A2_0003, 2'b10, 0, 0, 0, 0);
    apply_stimulus(1, 32'hA3A3_0004, 2'b11, 1, 0, 0, 0);
    #1;
    check_output("full_flag", 64'(full), 64'd1);
    check_output("full_in_ready", 64'(in_ready), 64'd0);
    check_output("locked_code", 64'(out_payload), 64'h1_A0A0_0001);
    apply_stimulus(1, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 2'b00, 0, 1, 0, 0);
    apply_stimulus(1, 32'hB5B5_0005, 2'b00, 0, 0, 1, 0);
    apply_stimulus(1, 32'hB6B6_0006, 2'b01, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 2'b00, 0, 1, 0, 0);
    apply_stimulus(0, 0, 2'b00, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 2'b00, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) apply_stimulus(0, 0, 2'b00, 0, 0, 1, 0);

    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(1, 32'hC0C0_0000 + 32'(i), 2'(i), 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) apply_stimulus(0, 0, 2'b00, 0, 1, 0, 0);
    apply_stimulus(0, 0, 2'b00, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 2'b00, 0, 1, 1, 0);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        apply_stimulus(1'($urandom_range(1)), $urandom, 2'($urandom_range(3)),
                       1'($urandom_range(1)), 1'($urandom_range(1)),
                       ($urandom_range(2) == 0), ($urandom_range(7) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
